rc6_block_sequencer: RTL and testbench

Controller that sequences rc6_core for streaming image encryption and decryption. It latches a key and mode, runs the key schedule, and accepts 128-bit blocks from an upstream valid/ready stream. Each block is issued to the core, and the result is returned on a downstream valid/ready stream. Only one block is in flight at a time; a watchdog flags a core that never responds.

---
 rtl/rc6_block_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_rc6_block_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc6_block_sequencer.sv
// rc6_block_sequencer
// Sequences an rc6_core for streaming block encryption and decryption. It
// latches a key and mode, runs the core key schedule, then takes one 128-bit
// block at a time from an upstream stream. Each block goes to the core, and
// the result is handed to a downstream stream. A saturating watchdog catches
// a core that never answers.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_cfg_key/flag/start     key, mode (1 = encrypt) and load pulse
//   i_s_data/valid, o_s_ready  upstream block stream
//   o_m_data/valid, i_m_ready  downstream result stream
//   o_core_*, i_core_*       rc6_core control and data
//   o_key_ready              key schedule done for the current key
//   o_busy                   high in every state except IDLE, READY and ERROR
//   o_blk_cnt                blocks delivered since the last cfg_start
//   o_timeout                sticky watchdog error
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid holds its data stable until that edge. Ready may rise
// without valid. Both streams here follow this rule.
module rc6_block_sequencer #(
  parameter int DATA_W  = 128,
  parameter int KEY_W   = 128,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [KEY_W-1:0]  i_cfg_key,
  input  logic              i_cfg_flag,
  input  logic              i_cfg_start,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic              o_core_flag,
  output logic [KEY_W-1:0]  o_core_key,
  output logic              o_core_key_en,
  input  logic              i_core_key_ok,
  output logic [DATA_W-1:0] o_core_din,
  output logic              o_core_din_en,
  input  logic [DATA_W-1:0] i_core_dout,
  input  logic              i_core_dout_en,
  output logic              o_key_ready,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_blk_cnt,
  output logic              o_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_KEY_LOAD = 3'd1;
  localparam logic [2:0] S_KEY_WAIT = 3'd2;
  localparam logic [2:0] S_READY    = 3'd3;
  localparam logic [2:0] S_ISSUE    = 3'd4;
  localparam logic [2:0] S_WAIT_OUT = 3'd5;
  localparam logic [2:0] S_OUTPUT   = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  logic [2:0]        r_state;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_s_ready;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_valid;
  logic              r_flag;
  logic [KEY_W-1:0]  r_key;
  logic              r_key_en;
  logic [DATA_W-1:0] r_din;
  logic              r_din_en;
  logic              r_key_ready;
  logic              r_busy;
  logic [CNT_W-1:0]  r_blk_cnt;
  logic              r_timeout;

  logic [2:0] w_next_state;
  logic       w_cfg_load;
  logic       w_key_seen;
  logic       w_accept;
  logic       w_dout_cap;
  logic       w_out_hs;
  logic       w_tmr_expired;

  // cfg_start only counts in the states that can take a new key; elsewhere
  // it is dropped, not queued.
  assign w_cfg_load    = i_cfg_start &&
                         (r_state == S_IDLE || r_state == S_READY || r_state == S_ERROR);
  // The timer is 0 in the first KEY_WAIT cycle. Requiring it to be non-zero
  // rejects a key_ok left over from the previous key.
  assign w_key_seen    = (r_state == S_KEY_WAIT) && i_core_key_ok && (r_tmr != '0);
  // cfg_start beats a same-cycle upstream valid.
  assign w_accept      = (r_state == S_READY) && !i_cfg_start && i_s_valid && r_s_ready;
  assign w_dout_cap    = (r_state == S_WAIT_OUT) && i_core_dout_en;
  assign w_out_hs      = (r_state == S_OUTPUT) && r_m_valid && i_m_ready;
  assign w_tmr_expired = (r_tmr == TMR_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_cfg_load) w_next_state = S_KEY_LOAD;
      S_KEY_LOAD: w_next_state = S_KEY_WAIT;
      S_KEY_WAIT: begin
        if (w_key_seen)         w_next_state = S_READY;
        else if (w_tmr_expired) w_next_state = S_ERROR;
      end
      S_READY: begin
        if (w_cfg_load)    w_next_state = S_KEY_LOAD;
        else if (w_accept) w_next_state = S_ISSUE;
      end
      S_ISSUE:    w_next_state = S_WAIT_OUT;
      S_WAIT_OUT: begin
        if (w_dout_cap)         w_next_state = S_OUTPUT;
        else if (w_tmr_expired) w_next_state = S_ERROR;
      end
      S_OUTPUT:   if (w_out_hs) w_next_state = S_READY;
      S_ERROR:    if (w_cfg_load) w_next_state = S_KEY_LOAD;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_s_ready   <= 1'b0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_flag      <= 1'b0;
      r_key       <= '0;
      r_key_en    <= 1'b0;
      r_din       <= '0;
      r_din_en    <= 1'b0;
      r_key_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_blk_cnt   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // State-decoded outputs are registered from the next state, so they
      // line up with the state they belong to.
      r_s_ready <= (w_next_state == S_READY);
      r_key_en  <= (w_next_state == S_KEY_LOAD);
      r_din_en  <= (w_next_state == S_ISSUE);
      r_busy    <= !(w_next_state == S_IDLE || w_next_state == S_READY ||
                     w_next_state == S_ERROR);

      if (w_cfg_load) begin
        r_key     <= i_cfg_key;
        r_flag    <= i_cfg_flag;
        r_blk_cnt <= '0;
        r_timeout <= 1'b0;
      end

      if (w_next_state == S_KEY_LOAD) r_key_ready <= 1'b0;
      else if (w_key_seen)            r_key_ready <= 1'b1;

      // The watchdog restarts before each wait and saturates, so it cannot
      // wrap back to zero.
      if (r_state == S_KEY_LOAD || r_state == S_ISSUE)
        r_tmr <= '0;
      else if ((r_state == S_KEY_WAIT || r_state == S_WAIT_OUT) && r_tmr != TMR_MAX)
        r_tmr <= r_tmr + 1'b1;

      if (w_accept) r_din <= i_s_data;

      if (w_dout_cap) begin
        r_m_data  <= i_core_dout;
        r_m_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_m_valid <= 1'b0;
        r_blk_cnt <= r_blk_cnt + 1'b1;
      end

      if (w_next_state == S_ERROR && r_state != S_ERROR) r_timeout <= 1'b1;
    end
  end

  assign o_s_ready     = r_s_ready;
  assign o_m_data      = r_m_data;
  assign o_m_valid     = r_m_valid;
  assign o_core_flag   = r_flag;
  assign o_core_key    = r_key;
  assign o_core_key_en = r_key_en;
  assign o_core_din    = r_din;
  assign o_core_din_en = r_din_en;
  assign o_key_ready   = r_key_ready;
  assign o_busy        = r_busy;
  assign o_blk_cnt     = r_blk_cnt;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_rc6_block_sequencer.sv
// Directed testbench for rc6_block_sequencer. A behavioural core model
// stands in for rc6_core. It raises key_ok a fixed number of cycles after
// key_en and returns a keyed, invertible transform of din a few cycles after
// din_en.
module tb_rc6_block_sequencer;

  localparam int DATA_W  = 128;
  localparam int KEY_W   = 128;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 1024;
  localparam int KEY_LAT = 20;
  localparam int CORE_LAT = 5;

  logic              clk;
  logic              rst;
  logic [KEY_W-1:0]  cfg_key;
  logic              cfg_flag;
  logic              cfg_start;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              core_flag;
  logic [KEY_W-1:0]  core_key;
  logic              core_key_en;
  logic              core_key_ok;
  logic [DATA_W-1:0] core_din;
  logic              core_din_en;
  logic [DATA_W-1:0] core_dout;
  logic              core_dout_en;
  logic              key_ready;
  logic              busy;
  logic [CNT_W-1:0]  blk_cnt;
  logic              timeout;

  rc6_block_sequencer #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_key(cfg_key), .i_cfg_flag(cfg_flag), .i_cfg_start(cfg_start),
    .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .o_m_data(m_data), .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_core_flag(core_flag), .o_core_key(core_key), .o_core_key_en(core_key_en),
    .i_core_key_ok(core_key_ok), .o_core_din(core_din), .o_core_din_en(core_din_en),
    .i_core_dout(core_dout), .i_core_dout_en(core_dout_en),
    .o_key_ready(key_ready), .o_busy(busy), .o_blk_cnt(blk_cnt), .o_timeout(timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference transform ----------------
  function automatic logic [127:0] ref_enc(input logic [127:0] d, input logic [127:0] k);
    return {d[119:0], d[127:120]} ^ k;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] c, input logic [127:0] k);
    logic [127:0] t;
    t = c ^ k;
    return {t[7:0], t[127:8]};
  endfunction

  // ---------------- core model ----------------
  int          ko_cnt;
  int          do_cnt;
  logic        core_enable;
  logic        spur;

  always @(posedge clk) begin
    core_key_ok  <= 1'b0;
    core_dout_en <= 1'b0;
    if (rst) begin
      ko_cnt    <= 0;
      do_cnt    <= 0;
      core_dout <= '0;
    end else begin
      if (core_key_en) ko_cnt <= KEY_LAT;
      else if (ko_cnt != 0) begin
        ko_cnt <= ko_cnt - 1;
        if (ko_cnt == 1) core_key_ok <= 1'b1;
      end
      if (core_din_en) do_cnt <= CORE_LAT;
      else if (do_cnt != 0) begin
        do_cnt <= do_cnt - 1;
        if (do_cnt == 1 && core_enable) begin
          core_dout_en <= 1'b1;
          core_dout    <= core_flag ? ref_enc(core_din, core_key) : ref_dec(core_din, core_key);
        end
      end
      if (spur) begin
        core_dout_en <= 1'b1;
        core_dout    <= {4{32'hDEADBEEF}};
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int key_en_cnt = 0;
  int din_en_cnt = 0;
  int out_cnt    = 0;
  int mvalid_seen = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (core_key_en) key_en_cnt++;
      if (core_din_en) din_en_cnt++;
      if (m_valid) mvalid_seen++;
      if (m_valid && m_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) chk("unexpected_output", m_data, '0);
        else chk("out_data", m_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_cfg(input logic [127:0] k, input logic f);
    cfg_key = k; cfg_flag = f; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_key_ready();
    int n = 0;
    while (!key_ready && n < 200) begin tick(); n++; end
    if (!key_ready) chk("key_ready_wait", 128'(key_ready), 128'(1));
  endtask

  task automatic wait_s_ready();
    int n = 0;
    while (!s_ready && n < 300) begin tick(); n++; end
    if (!s_ready) chk("s_ready_wait", 128'(s_ready), 128'(1));
  endtask

  task automatic send_block(input logic [127:0] d);
    s_data = d; s_valid = 1'b1;
    wait_s_ready();
    tick();
    s_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] key0;
  logic [127:0] pt [4];
  logic [127:0] held;
  int           base;
  int           bad;

  initial begin
    key0  = 128'h000102030405060708090A0B0C0D0E0F;
    pt[0] = 128'h00112233445566778899AABBCCDDEEFF;
    pt[1] = 128'hFFEEDDCCBBAA99887766554433221100;
    pt[2] = 128'h0123456789ABCDEF0123456789ABCDEF;
    pt[3] = 128'h80000000000000000000000000000001;
    rst = 1'b1; cfg_key = '0; cfg_flag = 1'b0; cfg_start = 1'b0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1; core_enable = 1'b1; spur = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    chk("rst_ctrl", 128'({s_ready, m_valid, core_key_en, core_din_en, key_ready, busy, timeout, core_flag}), '0);
    chk("rst_blk_cnt", 128'(blk_cnt), '0);
    chk("rst_key", core_key, '0);

    // key load: one key_en pulse, key_ready one cycle after key_ok
    start_cfg(key0, 1'b1);
    chk("key_load_busy", 128'({busy, core_key_en}), 128'(2'b11));
    begin
      int n = 0;
      while (!core_key_ok && n < 100) begin tick(); n++; end
    end
    chk("key_ok_seen", 128'(core_key_ok), 128'(1));
    chk("key_ready_before", 128'(key_ready), 128'(0));
    tick();
    chk("key_ready_after", 128'(key_ready), 128'(1));
    chk("ready_after_key", 128'(s_ready), 128'(1));
    chk("key_en_pulses", 128'(key_en_cnt), 128'(1));
    chk("core_key", core_key, key0);
    chk("core_flag", 128'(core_flag), 128'(1));

    // encrypt four blocks
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ref_enc(pt[i], key0));
      send_block(pt[i]);
    end
    wait_s_ready();
    chk("enc_blk_cnt", 128'(blk_cnt), 128'(4));
    chk("enc_din_pulses", 128'(din_en_cnt), 128'(4));
    chk("enc_out_cnt", 128'(out_cnt), 128'(4));

    // decrypt the ciphertexts back to the plaintexts
    start_cfg(key0, 1'b0);
    chk("dec_cnt_clear", 128'(blk_cnt), '0);
    wait_key_ready();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pt[i]);
      send_block(ref_enc(pt[i], key0));
    end
    wait_s_ready();
    chk("dec_blk_cnt", 128'(blk_cnt), 128'(4));
    chk("dec_out_cnt", 128'(out_cnt), 128'(8));

    // downstream backpressure with a spurious dout_en
    m_ready = 1'b0;
    exp_q.push_back(pt[1]);
    send_block(ref_enc(pt[1], key0));
    begin
      int n = 0;
      while (!m_valid && n < 100) begin tick(); n++; end
    end
    chk("bp_valid", 128'(m_valid), 128'(1));
    held = m_data;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      spur = (i == 10);
      tick();
      if (!m_valid || m_data !== held || s_ready) bad++;
    end
    spur = 1'b0;
    chk("bp_stable", 128'(bad), '0);
    chk("bp_data", held, pt[1]);
    m_ready = 1'b1;
    wait_s_ready();
    chk("bp_blk_cnt", 128'(blk_cnt), 128'(5));

    // cfg_start and s_valid together in READY
    base = din_en_cnt;
    s_data = pt[2]; s_valid = 1'b1;
    cfg_key = key0; cfg_flag = 1'b1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("race_s_ready", 128'(s_ready), 128'(0));
    chk("race_key_en", 128'(core_key_en), 128'(1));
    chk("race_blk_cnt", 128'(blk_cnt), '0);
    tick(); tick();
    chk("race_no_din", 128'(din_en_cnt - base), '0);
    exp_q.push_back(ref_enc(pt[2], key0));
    send_block(pt[2]);
    wait_s_ready();
    chk("race_accept_cnt", 128'(blk_cnt), 128'(1));

    // watchdog: core never answers
    core_enable = 1'b0;
    send_block(pt[3]);
    tick();
    chk("wd_busy", 128'(busy), 128'(1));
    bad = 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      if (timeout) bad++;
    end
    chk("wd_early", 128'(bad), '0);
    tick();
    chk("wd_timeout", 128'(timeout), 128'(1));
    chk("wd_idle_outs", 128'({s_ready, busy, core_din_en, core_key_en}), '0);
    repeat (20) tick();
    chk("wd_sticky", 128'(timeout), 128'(1));
    core_enable = 1'b1;
    start_cfg(key0, 1'b1);
    chk("wd_cleared", 128'({timeout, core_key_en}), 128'(2'b01));
    wait_key_ready();

    // reset while waiting on the core
    send_block(pt[0]);
    tick();
    chk("mid_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ctrl", 128'({s_ready, m_valid, core_key_en, core_din_en, key_ready, busy, timeout, core_flag}), '0);
    chk("mid_rst_data", m_data | core_din | core_key, '0);
    chk("mid_rst_cnt", 128'(blk_cnt), '0);
    base = mvalid_seen;
    repeat (20) tick();
    chk("mid_no_output", 128'(mvalid_seen - base), '0);
    chk("mid_still_idle", 128'({s_ready, busy}), '0);

    chk("exp_q_empty", 128'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
